// File: rtl/stride_prefetcher_if.sv
// stride_prefetcher_if: MEM-stage training inputs and the prefetch request port.
// Defining STRIDE_PF_STATS_EN adds the issued/dropped counter outputs.
interface stride_prefetcher_if;
   logic [31:0] mem_pc;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic        mem_resp;
   logic        demand_busy;
   logic        pf_read;
   logic [31:0] pf_address;
   logic        pf_resp;
`ifdef STRIDE_PF_STATS_EN
   logic [31:0] pf_issued_count;
   logic [31:0] pf_dropped_count;
   modport master (
      output mem_pc, mem_addr, mem_read, mem_write, mem_resp, demand_busy, pf_resp,
      input  pf_read, pf_address, pf_issued_count, pf_dropped_count
   );
   modport slave (
      input  mem_pc, mem_addr, mem_read, mem_write, mem_resp, demand_busy, pf_resp,
      output pf_read, pf_address, pf_issued_count, pf_dropped_count
   );
`else
   modport master (
      output mem_pc, mem_addr, mem_read, mem_write, mem_resp, demand_busy, pf_resp,
      input  pf_read, pf_address
   );
   modport slave (
      input  mem_pc, mem_addr, mem_read, mem_write, mem_resp, demand_busy, pf_resp,
      output pf_read, pf_address
   );
`endif
endinterface

// File: rtl/stride_prefetcher.sv
// stride_prefetcher: PC-indexed RPT trained on MEM-stage accesses, issuing one line prefetch at a time.
// Defining STRIDE_PF_STATS_EN adds saturating issued/dropped counters.
module stride_prefetcher #(
   parameter int IDX_BITS    = 4,
   parameter int OFFSET_BITS = 5
) (
   input logic               clk,
   input logic               reset,
   stride_prefetcher_if.slave bus
);
   localparam int N  = 1 << IDX_BITS;
   localparam int TW = 30 - IDX_BITS;
   typedef enum logic [1:0] {INIT, TRANSIENT, STEADY, NOPRED} rpt_st_t;
   typedef enum logic [1:0] {IDLE, PEND, REQ} fsm_t;
   logic          valid [N];
   logic [TW-1:0] tag [N];
   logic [31:0]   last_addr [N];
   logic [31:0]   stride [N];
   rpt_st_t       st [N];
   logic [IDX_BITS-1:0] idx;
   logic [TW-1:0] tg;
   logic          ev, hit, correct, cand_ok, drop, done, pend_valid, pend_valid_n, unused_bits;
   logic [31:0]   ns, line_mask, cand, pend_addr, pend_addr_n, pf_addr, pf_addr_n, last_issued, last_issued_n;
   rpt_st_t       cur, st_n;
   fsm_t          state, state_n;
   assign idx       = bus.mem_pc[IDX_BITS+1:2];
   assign tg        = bus.mem_pc[31:IDX_BITS+2];
   assign ev        = bus.mem_resp & (bus.mem_read | bus.mem_write);
   assign hit       = valid[idx] && tag[idx] == tg;
   assign cur       = st[idx];
   assign ns        = bus.mem_addr - last_addr[idx];
   assign correct   = ns == stride[idx];
   assign line_mask = ~((32'd1 << OFFSET_BITS) - 32'd1);
   assign cand      = (bus.mem_addr + stride[idx]) & line_mask;
   assign st_n = cur == INIT      ? (correct ? STEADY : TRANSIENT)
               : cur == TRANSIENT ? (correct ? STEADY : NOPRED)
               : cur == STEADY    ? (correct ? STEADY : INIT)
               :                    (correct ? TRANSIENT : NOPRED);
   assign cand_ok = ev && hit && st_n == STEADY && stride[idx] != 32'd0 &&
                    cand != (bus.mem_addr & line_mask) && cand != last_issued;
   assign unused_bits = ^{bus.mem_pc[1:0], drop, done};
   // Flop-based table: a write at this edge is already visible to the next cycle's read.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) valid[i] <= 1'b0;
      end else if (ev) begin
         valid[idx]     <= 1'b1;
         tag[idx]       <= tg;
         last_addr[idx] <= bus.mem_addr;
         stride[idx]    <= !hit ? 32'd0 : (!correct && cur != STEADY) ? ns : stride[idx];
         st[idx]        <= hit ? st_n : INIT;
      end
   end
   always_comb begin
      state_n       = state;
      pend_addr_n   = cand_ok ? cand : pend_addr;
      pend_valid_n  = pend_valid;
      pf_addr_n     = pf_addr;
      last_issued_n = last_issued;
      drop          = 1'b0;
      done          = 1'b0;
      case (state)
         IDLE: state_n = cand_ok ? PEND : IDLE;
         PEND: begin
            drop = cand_ok && bus.demand_busy;
            if (!bus.demand_busy) begin
               state_n      = REQ;
               pf_addr_n    = pend_addr;
               pend_valid_n = cand_ok;
            end
         end
         REQ: begin
            drop         = cand_ok && pend_valid;
            done         = bus.pf_resp;
            pend_valid_n = pend_valid | cand_ok;
            if (bus.pf_resp) begin
               last_issued_n = pf_addr;
               state_n       = (pend_valid | cand_ok) ? PEND : IDLE;
               pend_valid_n  = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pend_addr   <= '0;
         pend_valid  <= 1'b0;
         pf_addr     <= '0;
         last_issued <= '1;
      end else begin
         state       <= state_n;
         pend_addr   <= pend_addr_n;
         pend_valid  <= pend_valid_n;
         pf_addr     <= pf_addr_n;
         last_issued <= last_issued_n;
      end
   end
   assign bus.pf_read    = state == REQ;
   assign bus.pf_address = pf_addr;
`ifdef STRIDE_PF_STATS_EN
   logic [31:0] issued, dropped;
   always_ff @(posedge clk) begin
      if (reset) begin
         issued  <= '0;
         dropped <= '0;
      end else begin
         if (done && issued != '1) issued <= issued + 32'd1;
         if (drop && dropped != '1) dropped <= dropped + 32'd1;
      end
   end
   assign bus.pf_issued_count  = issued;
   assign bus.pf_dropped_count = dropped;
`endif
endmodule

// File: tb/tb_stride_prefetcher.sv
// tb_stride_prefetcher: per-cycle vector table for the training/issue scenarios plus
// hand-written sequences for latency, hold-stability and last_issued suppression.
module tb_stride_prefetcher;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;
   stride_prefetcher_if bus();
   stride_prefetcher #(.IDX_BITS(4), .OFFSET_BITS(5)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic        rst;
      logic [31:0] pc, addr;
      logic        rd, wr, resp, busy, pfr, e_rd, chk_a;
      logic [31:0] e_a;
   } vec_t;
   vec_t tbl[$];
   function automatic vec_t mk(logic rst, logic [31:0] pc, logic [31:0] addr, logic rd, logic wr,
                               logic resp, logic busy, logic pfr, logic e_rd, logic [31:0] e_a);
      vec_t v;
      v.rst = rst; v.pc = pc; v.addr = addr; v.rd = rd; v.wr = wr; v.resp = resp;
      v.busy = busy; v.pfr = pfr; v.e_rd = e_rd; v.e_a = e_a; v.chk_a = e_rd | rst;
      return v;
   endfunction
   function automatic vec_t acc(logic [31:0] pc, logic [31:0] addr, logic busy);
      return mk(1'b0, pc, addr, 1'b1, 1'b0, 1'b1, busy, 1'b0, 1'b0, 32'h0);
   endfunction
   function automatic vec_t wacc(logic [31:0] pc, logic [31:0] addr, logic e_rd, logic [31:0] e_a);
      return mk(1'b0, pc, addr, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, e_rd, e_a);
   endfunction
   function automatic vec_t idl(logic busy, logic pfr, logic e_rd, logic [31:0] e_a);
      return mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, busy, pfr, e_rd, e_a);
   endfunction
   function automatic vec_t rst_v();
      return mk(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endfunction
   function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endfunction
   task automatic apply(vec_t v);
      reset           = v.rst;
      bus.mem_pc      = v.pc;
      bus.mem_addr    = v.addr;
      bus.mem_read    = v.rd;
      bus.mem_write   = v.wr;
      bus.mem_resp    = v.resp;
      bus.demand_busy = v.busy;
      bus.pf_resp     = v.pfr;
      @(posedge clk);
      #1;
   endtask
   initial begin
      int lat;
      reset = 1'b0; bus.mem_pc = '0; bus.mem_addr = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      bus.mem_resp = 1'b0; bus.demand_busy = 1'b0; bus.pf_resp = 1'b0;
      tbl.push_back(rst_v());                                  // 0
      tbl.push_back(acc(32'h60, 32'h1000, 1'b0));              // 1 allocate
      tbl.push_back(acc(32'h60, 32'h1040, 1'b0));              // 2 transient
      tbl.push_back(acc(32'h60, 32'h1080, 1'b0));              // 3 steady, candidate
      tbl.push_back(idl(1'b0, 1'b0, 1'b1, 32'h10C0));          // 4 N+2
      tbl.push_back(idl(1'b0, 1'b0, 1'b1, 32'h10C0));          // 5 held
      tbl.push_back(idl(1'b0, 1'b1, 1'b0, 32'h0));             // 6 pf_resp
      tbl.push_back(acc(32'h64, 32'h2000, 1'b0));              // 7
      tbl.push_back(acc(32'h64, 32'h2004, 1'b0));              // 8
      tbl.push_back(acc(32'h64, 32'h2008, 1'b0));              // 9 same-line candidate
      tbl.push_back(idl(1'b0, 1'b0, 1'b0, 32'h0));             // 10
      tbl.push_back(acc(32'h68, 32'h2000, 1'b0));              // 11
      tbl.push_back(acc(32'h68, 32'h2040, 1'b0));              // 12
      tbl.push_back(acc(32'h68, 32'h2080, 1'b0));              // 13
      tbl.push_back(idl(1'b0, 1'b0, 1'b1, 32'h20C0));          // 14
      tbl.push_back(idl(1'b0, 1'b1, 1'b0, 32'h0));             // 15
      tbl.push_back(acc(32'h68, 32'h3000, 1'b0));              // 16 steady miss -> INIT
      tbl.push_back(idl(1'b0, 1'b0, 1'b0, 32'h0));             // 17
      tbl.push_back(acc(32'h68, 32'h3040, 1'b0));              // 18 kept stride -> steady
      tbl.push_back(idl(1'b0, 1'b0, 1'b1, 32'h3080));          // 19
      tbl.push_back(idl(1'b0, 1'b1, 1'b0, 32'h0));             // 20
      tbl.push_back(acc(32'h6C, 32'h4F40, 1'b1));              // 21
      tbl.push_back(acc(32'h6C, 32'h4F80, 1'b1));              // 22
      tbl.push_back(acc(32'h6C, 32'h4FC0, 1'b1));              // 23 candidate 0x5000
      tbl.push_back(acc(32'h6C, 32'h5000, 1'b1));              // 24 overwritten by 0x5040
      for (int k = 0; k < 6; k++) tbl.push_back(idl(1'b1, 1'b0, 1'b0, 32'h0)); // 25..30
      tbl.push_back(idl(1'b0, 1'b0, 1'b1, 32'h5040));          // 31
      tbl.push_back(idl(1'b1, 1'b0, 1'b1, 32'h5040));          // 32 not withdrawn
      tbl.push_back(idl(1'b0, 1'b1, 1'b0, 32'h0));             // 33
      tbl.push_back(idl(1'b0, 1'b0, 1'b0, 32'h0));             // 34
      tbl.push_back(acc(32'h460, 32'h10C0, 1'b0));             // 35 alias realloc
      tbl.push_back(idl(1'b0, 1'b0, 1'b0, 32'h0));             // 36
      tbl.push_back(acc(32'h460, 32'h1100, 1'b0));             // 37
      tbl.push_back(idl(1'b0, 1'b0, 1'b0, 32'h0));             // 38
      tbl.push_back(acc(32'h60, 32'h1140, 1'b0));              // 39
      tbl.push_back(idl(1'b0, 1'b0, 1'b0, 32'h0));             // 40
      tbl.push_back(acc(32'h70, 32'h8000, 1'b0));              // 41
      tbl.push_back(acc(32'h70, 32'h8040, 1'b0));              // 42
      tbl.push_back(acc(32'h70, 32'h8080, 1'b0));              // 43
      tbl.push_back(idl(1'b0, 1'b0, 1'b1, 32'h80C0));          // 44
      tbl.push_back(rst_v());                                  // 45 reset mid-request
      tbl.push_back(acc(32'h60, 32'h1000, 1'b0));              // 46
      tbl.push_back(acc(32'h60, 32'h1040, 1'b0));              // 47
      tbl.push_back(acc(32'h60, 32'h1080, 1'b0));              // 48
      tbl.push_back(idl(1'b0, 1'b0, 1'b1, 32'h10C0));          // 49
      tbl.push_back(idl(1'b0, 1'b1, 1'b0, 32'h0));             // 50
      tbl.push_back(idl(1'b0, 1'b1, 1'b0, 32'h0));             // 51 stray pf_resp
      tbl.push_back(wacc(32'h74, 32'h9000, 1'b0, 32'h0));      // 52
      tbl.push_back(wacc(32'h74, 32'h9040, 1'b0, 32'h0));      // 53
      tbl.push_back(mk(1'b0, 32'h74, 32'h7777, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0)); // 54
      tbl.push_back(wacc(32'h74, 32'h9080, 1'b0, 32'h0));      // 55
      tbl.push_back(idl(1'b0, 1'b0, 1'b1, 32'h90C0));          // 56
      tbl.push_back(wacc(32'h74, 32'h90C0, 1'b1, 32'h90C0));   // 57 candidate during REQ
      tbl.push_back(idl(1'b0, 1'b1, 1'b0, 32'h0));             // 58
      tbl.push_back(idl(1'b0, 1'b0, 1'b1, 32'h9100));          // 59
      tbl.push_back(idl(1'b0, 1'b1, 1'b0, 32'h0));             // 60
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         check($sformatf("v%0d_pf_read", i), {31'd0, bus.pf_read}, {31'd0, tbl[i].e_rd});
         if (tbl[i].chk_a) check($sformatf("v%0d_pf_address", i), bus.pf_address, tbl[i].e_a);
`ifdef STRIDE_PF_STATS_EN
         if (i == 34) begin
            check("stats_issued_mid", bus.pf_issued_count, 32'd4);
            check("stats_dropped_mid", bus.pf_dropped_count, 32'd1);
         end
`endif
      end
      // Negative stride: measure issue latency and hold stability.
      apply(acc(32'h78, 32'hA0C0, 1'b0));
      apply(acc(32'h78, 32'hA080, 1'b0));
      apply(acc(32'h78, 32'hA040, 1'b0));
      lat = 1;
      while (bus.pf_read !== 1'b1 && lat < 6) begin
         apply(idl(1'b0, 1'b0, 1'b0, 32'h0));
         lat++;
      end
      check("neg_latency", lat, 32'd2);
      check("neg_address", bus.pf_address, 32'hA000);
      for (int k = 0; k < 3; k++) begin
         apply(idl(k[0], 1'b0, 1'b0, 32'h0));
         check($sformatf("neg_hold%0d_read", k), {31'd0, bus.pf_read}, 32'd1);
         check($sformatf("neg_hold%0d_addr", k), bus.pf_address, 32'hA000);
      end
      apply(idl(1'b0, 1'b1, 1'b0, 32'h0));
      check("neg_done", {31'd0, bus.pf_read}, 32'd0);
      // Candidate equal to last_issued is suppressed.
      apply(acc(32'h7C, 32'h9F40, 1'b0));
      apply(acc(32'h7C, 32'h9F80, 1'b0));
      apply(acc(32'h7C, 32'h9FC0, 1'b0));
      for (int k = 0; k < 3; k++) begin
         apply(idl(1'b0, 1'b0, 1'b0, 32'h0));
         check($sformatf("dup_suppress%0d", k), {31'd0, bus.pf_read}, 32'd0);
      end
`ifdef STRIDE_PF_STATS_EN
      check("stats_issued_end", bus.pf_issued_count, 32'd4);
      check("stats_dropped_end", bus.pf_dropped_count, 32'd0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/stride_prefetcher.md
Name: stride_prefetcher

Overview:
- Sits directly downstream of the CPU's MEM stage, beside the data cache.
- Consumes the MEM-stage PC and the data access address/handshake, and trains a PC-indexed reference prediction table (RPT).
- For loads/stores with a stable stride, issues one line-aligned prefetch read to the L2/physical-memory arbiter port.
- Never stalls the pipeline; every prefetch is advisory.

Parameters:
- IDX_BITS, 4, RPT index width; the table holds 2^IDX_BITS entries.
- OFFSET_BITS, 5, log2 of the cache line size in bytes (32-byte lines).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_pc  in  32  PC of the instruction currently in MEM.
- mem_addr  in  32  data-cache byte address (address_b).
- mem_read  in  1  MEM-stage load request.
- mem_write  in  1  MEM-stage store request.
- mem_resp  in  1  data-cache response; the access completes this cycle.
- demand_busy  in  1  demand miss in flight at the memory arbiter.
- pf_read  out  1  prefetch read request.
- pf_address  out  32  line-aligned prefetch address.
- pf_resp  in  1  arbiter completion of the prefetch line fill.

Behaviour:
- Training event: mem_resp & (mem_read | mem_write), sampled once per cycle.
- Index is mem_pc[IDX_BITS+1:2]. Tag is mem_pc[31:IDX_BITS+2].
- Entry fields: valid, tag, last_addr[31:0], stride[31:0] (two's complement), st[1:0].
- Entry states: INIT=0, TRANSIENT=1, STEADY=2, NOPRED=3.
- Miss (invalid entry or tag mismatch): allocate the entry with last_addr=mem_addr, stride=0, st=INIT. No prefetch candidate.
- Hit: compute ns = mem_addr - last_addr (32-bit wrap). correct = (ns == stride).
- Hit transitions:
  - INIT: correct -> STEADY; incorrect -> TRANSIENT, stride=ns.
  - TRANSIENT: correct -> STEADY; incorrect -> NOPRED, stride=ns.
  - STEADY: correct -> STEADY; incorrect -> INIT, stride kept.
  - NOPRED: correct -> TRANSIENT; incorrect -> NOPRED, stride=ns.
- last_addr is updated to mem_addr on every hit.
- Table writes take effect next cycle. Back-to-back events to the same index must see the updated entry (bypass).
- Candidate: produced only when the hit's next state is STEADY and stride != 0.
  - cand = (mem_addr + stride) with the low OFFSET_BITS bits cleared.
  - Suppressed if cand equals the line of mem_addr.
  - Suppressed if cand equals last_issued (last_issued resets to 0xFFFFFFFF).
- Issue FSM states: IDLE, PEND, REQ.
  - IDLE: a candidate is latched into pend_addr -> PEND.
  - PEND: if !demand_busy -> REQ and latch pf_address=pend_addr. A new candidate overwrites pend_addr.
  - REQ: pf_read=1 and pf_address held stable until pf_resp. On pf_resp: last_issued=pf_address, pf_read=0 the next cycle, -> IDLE (or -> PEND if a candidate arrived during REQ; see below).
  - A candidate arriving in REQ is held in pend_addr (one-deep, newest wins). It is issued after the current request completes.
  - pf_read may only rise while demand_busy=0. Once high it is not withdrawn for demand_busy.
- Latency: training event at cycle N -> earliest pf_read at cycle N+2 when the FSM is IDLE and demand_busy=0.
- Reset (including mid-request):
  - All entries invalid; FSM=IDLE.
  - pf_read=0, pf_address=0, last_issued=0xFFFFFFFF from the cycle after reset is sampled.
  - An in-flight request is abandoned; the arbiter is reset by the same signal.
- mem_resp without mem_read/mem_write is ignored.
- pf_resp while not in REQ is ignored.

Optional Feature:
- Macro: STRIDE_PF_STATS_EN.
- Defined: adds outputs pf_issued_count[31:0] and pf_dropped_count[31:0], both reset to 0.
  - issued increments on each pf_resp in REQ.
  - dropped increments when a pending candidate is overwritten before issue.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Same PC 0x60 accesses 0x1000, 0x1040, 0x1080 with demand_busy=0 -> entry goes INIT, TRANSIENT, STEADY. pf_read rises two cycles after the third response with pf_address=0x10C0, held until pf_resp.
- Stride +4 from PC 0x64 (0x2000, 0x2004, 0x2008) -> candidate 0x2000 is in the same line, so pf_read stays 0.
- STEADY entry (stride 0x40) sees access 0x3000 after 0x2080 -> st=INIT, stride stays 0x40, no prefetch. The next access at 0x3040 -> STEADY, pf_address=0x3080.
- Candidate 0x5000 with demand_busy=1 for 10 cycles, and a second candidate 0x5040 arriving in PEND -> only 0x5040 is requested, after demand_busy falls. With STRIDE_PF_STATS_EN, dropped=1.
- Alias: PC 0x60 then PC 0x460 (same index, different tag) -> reallocation, st=INIT, no prefetch. Then assert reset while pf_read=1 -> next cycle pf_read=0, and a re-trained repeat of the first sequence prefetches 0x10C0 again.
